// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: IF-stage PC register with branch/jump redirect, one-bubble squash and branch statistics
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic             branch_taken,
  input  logic [31:0]      id_br_target,
  input  logic             id_jump,
  input  logic [31:0]      id_jmp_target,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             misalign_err
);
  typedef enum logic {RUN, REDIR} state_t;
  state_t state, state_nx;
  logic run, br_hit, is_br, redirect;
  logic [31:0] target;
  always_ff @(posedge clk)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  always_comb begin
    run      = (state == RUN) && !stall;
    br_hit   = (id_beq && branch_taken) || (id_bne && !branch_taken);
    is_br    = id_beq || id_bne;
    redirect = run && (id_jump || br_hit);
    target   = id_jump ? id_jmp_target : id_br_target;
    state_nx = stall ? state : (redirect ? REDIR : RUN);
  end
  always_comb begin
    pc_plus4    = pc_out + 32'd4;
    if_id_flush = redirect;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      pc_out       <= RESET_PC;
      branch_cnt   <= '0;
      taken_cnt    <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (!stall) pc_out <= redirect ? {target[31:2], 2'b00} : pc_plus4;
      if (run && is_br && !(&branch_cnt)) branch_cnt <= branch_cnt + 1'b1;
      if (run && br_hit && !(&taken_cnt)) taken_cnt <= taken_cnt + 1'b1;
      if (redirect && |target[1:0]) misalign_err <= 1'b1;
    end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: random and directed checks of pc_redirect_ctrl against a behavioural model
module tb_pc_redirect_ctrl;
  logic clk = 0, rst_n, stall, id_beq, id_bne, branch_taken, id_jump;
  logic [31:0] id_br_target, id_jmp_target;
  logic [31:0] pc_out, pc_plus4, pc_out2, pc_plus4_2;
  logic if_id_flush, if_id_flush2, misalign_err, misalign_err2;
  logic [15:0] branch_cnt, taken_cnt;
  logic [1:0] branch_cnt2, taken_cnt2;
  int n_cmp = 0, n_err = 0;
  logic [31:0] m_pc;
  logic m_bubble, m_err;
  int m_bc, m_tc;
  always #5 clk = ~clk;
  pc_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .id_beq(id_beq), .id_bne(id_bne),
    .branch_taken(branch_taken), .id_br_target(id_br_target), .id_jump(id_jump),
    .id_jmp_target(id_jmp_target), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .if_id_flush(if_id_flush), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt),
    .misalign_err(misalign_err)
  );
  pc_redirect_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .id_beq(id_beq), .id_bne(id_bne),
    .branch_taken(branch_taken), .id_br_target(id_br_target), .id_jump(id_jump),
    .id_jmp_target(id_jmp_target), .pc_out(pc_out2), .pc_plus4(pc_plus4_2),
    .if_id_flush(if_id_flush2), .branch_cnt(branch_cnt2), .taken_cnt(taken_cnt2),
    .misalign_err(misalign_err2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_state();
    check("pc", pc_out, m_pc);
    check("pc2", pc_out2, m_pc);
    check("branch_cnt", 32'(branch_cnt), m_bc > 65535 ? 65535 : m_bc);
    check("taken_cnt", 32'(taken_cnt), m_tc > 65535 ? 65535 : m_tc);
    check("branch_cnt_w2", 32'(branch_cnt2), m_bc > 3 ? 3 : m_bc);
    check("taken_cnt_w2", 32'(taken_cnt2), m_tc > 3 ? 3 : m_tc);
    check("misalign", 32'(misalign_err), 32'(m_err));
    check("misalign2", 32'(misalign_err2), 32'(m_err));
  endtask
  task automatic cyc(input logic r, s, beq, bne, bt, jmp, input logic [31:0] btgt, jtgt);
    logic hit, go;
    logic [31:0] t;
    @(negedge clk);
    rst_n = r; stall = s; id_beq = beq; id_bne = bne; branch_taken = bt;
    id_jump = jmp; id_br_target = btgt; id_jmp_target = jtgt;
    hit = (beq && bt) || (bne && !bt);
    go = !s && !m_bubble && (jmp || hit);
    t = jmp ? jtgt : btgt;
    #1;
    check("flush", 32'(if_id_flush), 32'(go));
    check("flush2", 32'(if_id_flush2), 32'(go));
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    @(posedge clk);
    if (!r) begin
      m_pc = 32'h0; m_bubble = 0; m_bc = 0; m_tc = 0; m_err = 0;
    end else if (!s) begin
      if (!m_bubble && (beq || bne)) m_bc++;
      if (!m_bubble && hit) m_tc++;
      if (go) begin
        m_pc = t & ~32'd3;
        m_err = m_err || (t % 4 != 0);
      end else m_pc = m_pc + 32'd4;
      m_bubble = go;
    end
    #1;
    check_state();
  endtask
  initial begin
    logic [31:0] a, b;
    rst_n = 0; stall = 0; id_beq = 0; id_bne = 0; branch_taken = 0; id_jump = 0;
    id_br_target = 0; id_jmp_target = 0;
    repeat (2) @(posedge clk);
    m_pc = 32'h0; m_bubble = 0; m_bc = 0; m_tc = 0; m_err = 0;
    #1;
    check("reset_pc", pc_out, 32'h0);
    check("reset_flush", 32'(if_id_flush), 32'h0);
    check_state();
    repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("pc_at_0x10", pc_out, 32'h10);
    cyc(1, 0, 1, 0, 1, 0, 32'h40, 0);
    check("beq_redirect", pc_out, 32'h40);
    cyc(1, 0, 1, 0, 1, 0, 32'h200, 0);
    check("redir_ignore_beq", pc_out, 32'h44);
    cyc(1, 0, 0, 1, 1, 0, 32'h80, 0);
    cyc(1, 0, 0, 1, 0, 0, 32'h80, 0);
    check("bne_redirect", pc_out, 32'h80);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 1, 0, 1, 0, 32'h300, 0);
    check("stall_freeze", pc_out, 32'h84);
    cyc(1, 0, 1, 0, 1, 0, 32'h300, 0);
    check("stall_release", pc_out, 32'h300);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 1, 32'h40, 32'h100);
    check("jump_priority", pc_out, 32'h100);
    cyc(1, 0, 1, 0, 1, 0, 32'h40, 0);
    cyc(1, 0, 1, 0, 1, 0, 32'h42, 0);
    check("misalign_pc", pc_out, 32'h40);
    check("misalign_set", 32'(misalign_err), 32'h1);
    repeat (3) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0, 0, 32'h500, 0);
    end
    check("sat_w2", 32'(taken_cnt2), 32'h3);
    cyc(1, 0, 1, 0, 1, 0, 32'h40, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_in_redir", pc_out, 32'h0);
    cyc(1, 0, 1, 0, 1, 0, 32'h60, 0);
    check("run_after_reset", pc_out, 32'h60);
    for (int i = 0; i < 3000; i++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 19) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 19) != 0) b[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF8;
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
          $urandom_range(0, 4) == 0, a, b);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
